// File: rtl/topbus_master.sv
// Register-access master for a multiplexed address/data bus with ALE, WRITE and READ strobes.
// Optional last-address cache enabled by defining TOPBUS_MASTER_ADDR_CACHE_EN.
module topbus_master #(
    parameter int unsigned T_SETUP  = 1,
    parameter int unsigned T_STROBE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rnw,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [7:0] bus_data_out,
    output logic       bus_data_oe,
    input  logic [7:0] bus_data_in,
    output logic       bus_ale,
    output logic       bus_write,
    output logic       bus_read
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ASETUP = 3'd1;
    localparam logic [2:0] S_ALE    = 3'd2;
    localparam logic [2:0] S_AHOLD  = 3'd3;
    localparam logic [2:0] S_DSETUP = 3'd4;
    localparam logic [2:0] S_STROBE = 3'd5;
    localparam logic [2:0] S_DHOLD  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    // Counter holds remaining cycles minus one; a zero length is treated as one.
    localparam logic [3:0] LEN_SU   = (T_SETUP == 0) ? 4'd1 : 4'(T_SETUP);
    localparam logic [3:0] LEN_ST   = (T_STROBE == 0) ? 4'd1 : 4'(T_STROBE);
    localparam logic [3:0] LAST_SU  = LEN_SU - 4'd1;
    localparam logic [3:0] LAST_ST  = LEN_ST - 4'd1;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rnw_q, rnw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] rdata_q, rdata_d;
    logic       cnt_done;
    logic       accept;
    logic       addr_hit;

    assign cnt_done = (cnt_q == 4'd0);
    assign accept   = (state_q == S_IDLE) && cmd_valid;

`ifdef TOPBUS_MASTER_ADDR_CACHE_EN
    logic [7:0] cache_addr_q, cache_addr_d;
    logic       cache_vld_q, cache_vld_d;

    assign addr_hit = cache_vld_q && (cmd_addr == cache_addr_q);

    always_comb begin
        cache_addr_d = cache_addr_q;
        cache_vld_d  = cache_vld_q;
        if ((state_q == S_ALE) && cnt_done) begin
            cache_addr_d = addr_q;
            cache_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_addr_q <= 8'h00;
            cache_vld_q  <= 1'b0;
        end else begin
            cache_addr_q <= cache_addr_d;
            cache_vld_q  <= cache_vld_d;
        end
    end
`else
    assign addr_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_done ? 4'd0 : (cnt_q - 4'd1);
        case (state_q)
            S_IDLE: begin
                cnt_d = LAST_SU;
                if (cmd_valid) begin
                    state_d = addr_hit ? S_DSETUP : S_ASETUP;
                end
            end
            S_ASETUP: begin
                if (cnt_done) begin
                    state_d = S_ALE;
                    cnt_d   = LAST_ST;
                end
            end
            S_ALE: begin
                if (cnt_done) begin
                    state_d = S_AHOLD;
                    cnt_d   = 4'd0;
                end
            end
            S_AHOLD: begin
                state_d = S_DSETUP;
                cnt_d   = LAST_SU;
            end
            S_DSETUP: begin
                if (cnt_done) begin
                    state_d = S_STROBE;
                    cnt_d   = LAST_ST;
                end
            end
            S_STROBE: begin
                if (cnt_done) begin
                    state_d = S_DHOLD;
                    cnt_d   = 4'd0;
                end
            end
            S_DHOLD: begin
                state_d = S_DONE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        if (accept) begin
            rnw_d   = cmd_rnw;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
        end
        // Sample on the edge that ends the last strobe cycle, READ still low.
        if ((state_q == S_STROBE) && cnt_done && rnw_q) begin
            cap_d = bus_data_in;
        end
        if ((state_q == S_DHOLD) && rnw_q) begin
            rdata_d = cap_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rnw_q   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            cap_q   <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    logic addr_phase;
    logic wr_phase;

    assign addr_phase = (state_q == S_ASETUP) || (state_q == S_ALE) ||
                        (state_q == S_AHOLD);
    assign wr_phase   = !rnw_q && ((state_q == S_DSETUP) ||
                        (state_q == S_STROBE) || (state_q == S_DHOLD));

    assign cmd_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_DONE);
    assign rsp_rdata    = rdata_q;
    assign bus_data_oe  = addr_phase || wr_phase;
    assign bus_data_out = addr_phase ? addr_q : (wr_phase ? wdata_q : 8'h00);
    assign bus_ale      = (state_q == S_ALE);
    assign bus_write    = !((state_q == S_STROBE) && !rnw_q);
    assign bus_read     = !((state_q == S_STROBE) && rnw_q);

endmodule

// File: tb/tb_topbus_master.sv
// Directed bench for topbus_master with a behavioural bus responder.
// Build with TOPBUS_MASTER_ADDR_CACHE_EN to check the address-cache variant.
module tb_topbus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_rnw;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] bus_data_out, bus_data_in;
    logic       bus_data_oe, bus_ale, bus_write, bus_read;

    logic       cmd_valid2, cmd_ready2, cmd_rnw2;
    logic [7:0] cmd_addr2, cmd_wdata2;
    logic       rsp_valid2;
    logic [7:0] rsp_rdata2, bus_data_out2;
    logic       bus_data_oe2, bus_ale2, bus_write2, bus_read2;

    always #5 clk = ~clk;

    topbus_master u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        .bus_data_in(bus_data_in), .bus_ale(bus_ale),
        .bus_write(bus_write), .bus_read(bus_read)
    );

    topbus_master #(.T_SETUP(3), .T_STROBE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_rnw(cmd_rnw2), .cmd_addr(cmd_addr2), .cmd_wdata(cmd_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .bus_data_out(bus_data_out2), .bus_data_oe(bus_data_oe2),
        .bus_data_in(8'h00), .bus_ale(bus_ale2),
        .bus_write(bus_write2), .bus_read(bus_read2)
    );

`ifdef TOPBUS_MASTER_ADDR_CACHE_EN
    localparam int HIT_CYC = 5;
    localparam int HIT_ALE = 0;
    localparam int HIT_GAP = 6;
`else
    localparam int HIT_CYC = 9;
    localparam int HIT_ALE = 1;
    localparam int HIT_GAP = 10;
`endif

    // Responder: unwritten registers read back as addr ^ 8'hF7.
    logic [7:0] mem [256];
    bit         wr_flag [256];
    logic [7:0] resp_addr = 8'h00;
    logic [7:0] wr_rise_data = 8'h00;
    logic       wr_rise_oe = 1'b0;
    int         ale_falls = 0;
    int         wr_count = 0;
    int         strobe_edges = 0;
    int         excl_bad = 0;

    always @(negedge bus_ale) begin
        if (rst_n === 1'b1) begin
            resp_addr = bus_data_out;
            ale_falls++;
        end
    end

    always @(posedge bus_write) begin
        if (rst_n === 1'b1) begin
            mem[resp_addr] = bus_data_out;
            wr_flag[resp_addr] = 1'b1;
            wr_rise_data = bus_data_out;
            wr_rise_oe = bus_data_oe;
            wr_count++;
        end
    end

    always @(posedge bus_write or negedge bus_write or
             posedge bus_read or negedge bus_read) begin
        strobe_edges++;
    end

    assign bus_data_in = (bus_read === 1'b0) ?
        (wr_flag[resp_addr] ? mem[resp_addr] : (resp_addr ^ 8'hF7)) : 8'h00;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ((int'(bus_ale) + int'(!bus_write) + int'(!bus_read)) > 1)
                excl_bad++;
            if ((int'(bus_ale2) + int'(!bus_write2) + int'(!bus_read2)) > 1)
                excl_bad++;
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input logic rnw, input logic [7:0] addr,
                           input logic [7:0] wdata, output int cyc,
                           output logic [7:0] rd, output int oe_bad,
                           output logic rdy_before, output logic rdy_after);
        int since;
        int f0;
        @(negedge clk);
        rdy_before = cmd_ready;
        cmd_valid = 1'b1;
        cmd_rnw = rnw;
        cmd_addr = addr;
        cmd_wdata = wdata;
        f0 = ale_falls;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr = 8'hEE;
        cmd_wdata = 8'hEE;
        cyc = 0;
        rd = 8'hxx;
        oe_bad = 0;
        since = -1;
        for (int k = 1; k <= 40; k++) begin
            if (since >= 0) since++;
            else if (ale_falls != f0) since = 0;
            if (rnw && since >= 1 && !rsp_valid && bus_data_oe) oe_bad++;
            if (rsp_valid) begin
                cyc = k;
                rd = rsp_rdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rdy_after = cmd_ready;
    endtask

    typedef struct {
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         cyc;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int cyc, oe_bad, f0, e0, w0, rsps, acc, ale_n, ds, st;
        int acc_c [3];
        logic [7:0] rd;
        logic rb, ra, wseen;

        vecs[0] = '{1'b0, 8'h12, 8'hA5, 9, 8'h00};
        vecs[1] = '{1'b1, 8'hFD, 8'h00, 9, 8'h0A};
        vecs[2] = '{1'b0, 8'h33, 8'h5C, 9, 8'h0A};
        vecs[3] = '{1'b1, 8'h12, 8'h00, 9, 8'hA5};
        vecs[4] = '{1'b0, 8'h80, 8'hFF, 9, 8'hA5};
        vecs[5] = '{1'b1, 8'h80, 8'h00, HIT_CYC, 8'hFF};
        vecs[6] = '{1'b0, 8'h01, 8'h3C, 9, 8'hFF};
        vecs[7] = '{1'b1, 8'h33, 8'h00, 9, 8'h5C};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        cmd_valid2 = 1'b0; cmd_rnw2 = 1'b0; cmd_addr2 = 8'h00; cmd_wdata2 = 8'h00;
        #12;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_data_out", bus_data_out, 8'h00);
        chk("rst_oe", bus_data_oe, 0);
        chk("rst_ale", bus_ale, 0);
        chk("rst_write", bus_write, 1);
        chk("rst_read", bus_read, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].rnw, vecs[i].addr, vecs[i].wdata,
                    cyc, rd, oe_bad, rb, ra);
            chk($sformatf("v%0d_ready_before", i), rb, 1);
            chk($sformatf("v%0d_rsp_cycle", i), cyc, vecs[i].cyc);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_ready_after", i), ra, 1);
            chk($sformatf("v%0d_ale_addr", i), resp_addr, vecs[i].addr);
            if (vecs[i].rnw) begin
                chk($sformatf("v%0d_read_oe", i), oe_bad, 0);
            end else begin
                chk($sformatf("v%0d_wr_rise_data", i), wr_rise_data, vecs[i].wdata);
                chk($sformatf("v%0d_wr_rise_oe", i), wr_rise_oe, 1);
            end
        end

        // Reset asserted in the middle of a write strobe.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 8'h44; cmd_wdata = 8'h77;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 30 && bus_write !== 1'b0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_reached_strobe", bus_write, 0);
        #2;
        w0 = wr_count;
        rst_n = 1'b0;
        #1;
        chk("abort_write_high", bus_write, 1);
        chk("abort_oe_low", bus_data_oe, 0);
        e0 = strobe_edges;
        rsps = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rsp_valid) rsps++;
        end
        chk("abort_no_rsp", rsps, 0);
        chk("abort_no_edges", strobe_edges - e0, 0);
        chk("abort_no_reg_write", wr_count - w0, 0);
        chk("abort_reg_untouched", wr_flag[8'h44], 0);
        @(negedge clk);
        rst_n = 1'b1;
        f0 = ale_falls;
        run_cmd(1'b0, 8'h44, 8'h88, cyc, rd, oe_bad, rb, ra);
        chk("post_abort_ready", rb, 1);
        chk("post_abort_cycle", cyc, 9);
        chk("post_abort_ale", ale_falls - f0, 1);
        chk("post_abort_reg", mem[8'h44], 8'h88);

        // Repeated address, then a different one.
        run_cmd(1'b0, 8'h10, 8'h01, cyc, rd, oe_bad, rb, ra);
        chk("cache_first_cycle", cyc, 9);
        f0 = ale_falls;
        run_cmd(1'b0, 8'h10, 8'h02, cyc, rd, oe_bad, rb, ra);
        chk("cache_second_cycle", cyc, HIT_CYC);
        chk("cache_second_ale", ale_falls - f0, HIT_ALE);
        chk("cache_second_reg", mem[8'h10], 8'h02);
        f0 = ale_falls;
        run_cmd(1'b1, 8'h11, 8'h00, cyc, rd, oe_bad, rb, ra);
        chk("cache_read_cycle", cyc, 9);
        chk("cache_read_ale", ale_falls - f0, 1);
        chk("cache_read_data", rd, 8'hE6);
        chk("cache_read_oe", oe_bad, 0);

        // cmd_valid held high for three back-to-back writes.
        acc = 0;
        rsps = 0;
        w0 = wr_count;
        acc_c[0] = 0; acc_c[1] = 0; acc_c[2] = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            cmd_valid = (acc < 3);
            cmd_rnw = 1'b0;
            cmd_addr = 8'h10;
            cmd_wdata = 8'(acc + 1);
            if (cmd_valid && cmd_ready) begin
                acc_c[acc] = c;
                acc++;
            end
            @(posedge clk);
            #1;
            if (rsp_valid) rsps++;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", acc, 3);
        chk("b2b_rsps", rsps, 3);
        chk("b2b_writes", wr_count - w0, 3);
        chk("b2b_gap1", acc_c[1] - acc_c[0], 10);
        chk("b2b_gap2", acc_c[2] - acc_c[1], HIT_GAP);
        chk("b2b_reg", mem[8'h10], 8'h03);

        // Second instance: T_SETUP=3, T_STROBE=1.
        @(negedge clk);
        cmd_valid2 = 1'b1; cmd_rnw2 = 1'b0; cmd_addr2 = 8'h5A; cmd_wdata2 = 8'hC3;
        @(posedge clk);
        #1;
        cmd_valid2 = 1'b0;
        cyc = 0; ale_n = 0; ds = 0; st = 0; wseen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus_ale2) ale_n++;
            if (!bus_write2) begin
                st++;
                wseen = 1'b1;
            end
            if (!wseen && bus_data_oe2 && bus_write2 && bus_data_out2 == 8'hC3) ds++;
            if (rsp_valid2) begin
                cyc = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("t31_rsp_cycle", cyc, 11);
        chk("t31_ale_len", ale_n, 1);
        chk("t31_dsetup_len", ds, 3);
        chk("t31_strobe_len", st, 1);

        chk("strobes_exclusive", excl_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
